// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller and its data path:
// FSM state codes, opcode/funct values, ALU operation and mux-select codes.
package ctrl_pkg;

   typedef enum logic [4:0] {
      ST_IF       = 5'd0,
      ST_ID       = 5'd1,
      ST_EX_R     = 5'd2,
      ST_WB_R     = 5'd3,
      ST_EX_I     = 5'd4,
      ST_WB_I     = 5'd5,
      ST_MEM_ADDR = 5'd6,
      ST_MEM_RD   = 5'd7,
      ST_WB_LW    = 5'd8,
      ST_MEM_WR   = 5'd9,
      ST_BR       = 5'd10,
      ST_J        = 5'd11,
      ST_JAL      = 5'd12,
      ST_JR       = 5'd13,
      ST_LUI      = 5'd14,
      ST_ERROR    = 5'd31
   } state_t;

   // Opcodes (Inst_R[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_LUI   = 6'b001111;

   // R-type funct codes (Inst_R[5:0])
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_NOR = 6'b100111;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_XOR = 6'b100110;
   localparam logic [5:0] FN_JR  = 6'b001000;

   // ALU_operation codes
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_XOR = 3'b011;
   localparam logic [2:0] ALU_NOR = 3'b100;
   localparam logic [2:0] ALU_SRL = 3'b101;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // Mux selects
   localparam logic [1:0] REGDST_RT  = 2'b00;
   localparam logic [1:0] REGDST_RD  = 2'b01;
   localparam logic [1:0] REGDST_RA  = 2'b10;
   localparam logic [1:0] M2R_ALUOUT = 2'b00;
   localparam logic [1:0] M2R_MDR    = 2'b01;
   localparam logic [1:0] M2R_PC     = 2'b10;
   localparam logic [1:0] M2R_LUI    = 2'b11;
   localparam logic [1:0] SRCB_RT    = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;
   localparam logic [1:0] PCSRC_ALU  = 2'b00;
   localparam logic [1:0] PCSRC_OUT  = 2'b01;
   localparam logic [1:0] PCSRC_JMP  = 2'b10;
   localparam logic [1:0] PCSRC_RS   = 2'b11;

   // Instruction decode captured in ID and held for the rest of the instruction
   typedef struct packed {
      logic [2:0] alu_op;
      logic       illegal;
      logic       is_lw;
      logic       is_beq;
      logic       ovf_chk;
   } decode_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode/funct to ALU_operation decode, with an illegal-funct
// flag for R-type and a flag marking the signed ops that can overflow.
module alu_op_decode
   import ctrl_pkg::*;
(
   input  logic [5:0] OPcode,
   input  logic [5:0] Fun,
   output logic [2:0] alu_op,
   output logic       illegal,
   output logic       ovf_chk
);

   // Table lookup; unlisted R-type funct is illegal and falls back to add
   always_comb begin
      alu_op  = ALU_ADD;
      illegal = 1'b0;
      ovf_chk = 1'b0;
      if (OPcode == OP_RTYPE) begin
         case (Fun)
            FN_ADD:  begin alu_op = ALU_ADD; ovf_chk = 1'b1; end
            FN_SUB:  begin alu_op = ALU_SUB; ovf_chk = 1'b1; end
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_NOR:  alu_op = ALU_NOR;
            FN_SLT:  alu_op = ALU_SLT;
            FN_SRL:  alu_op = ALU_SRL;
            FN_XOR:  alu_op = ALU_XOR;
            default: illegal = 1'b1;
         endcase
      end else begin
         case (OPcode)
            OP_ADDI: begin alu_op = ALU_ADD; ovf_chk = 1'b1; end
            OP_ANDI: alu_op = ALU_AND;
            OP_ORI:  alu_op = ALU_OR;
            OP_SLTI: alu_op = ALU_SLT;
            default: alu_op = ALU_ADD;
         endcase
      end
   end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EX/MEM/WB and drives every
// data-path control input. Outputs are decoded from the registered state and
// the decode latched in ID; IRWrite/PCWrite in IF follow MIO_ready directly.
// Optional: define OVERFLOW_TRAP_EN to trap add/sub/addi overflow to ERROR.
module multi_cycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int unsigned STATE_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         OPcode,
   input  logic [5:0]         Fun,
   input  logic               zero,
   input  logic               overflow,
   input  logic               MIO_ready,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               CPU_MIO,
   output logic               IorD,
   output logic               IRWrite,
   output logic [1:0]         RegDst,
   output logic               RegWrite,
   output logic [1:0]         MemtoReg,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         PCSource,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic               Branch,
   output logic [2:0]         ALU_operation,
   output logic               exc,
   output logic [STATE_W-1:0] state_out
);

   state_t     state;
   decode_t    dec_q;
   logic [2:0] dec_alu_op;
   logic       dec_illegal;
   logic       dec_ovf_chk;
   logic       trap;
   logic       unused_inputs;

   alu_op_decode u_alu_op_decode (
      .OPcode  (OPcode),
      .Fun     (Fun),
      .alu_op  (dec_alu_op),
      .illegal (dec_illegal),
      .ovf_chk (dec_ovf_chk)
   );

`ifdef OVERFLOW_TRAP_EN
   logic ovf_q;
   assign trap          = ovf_q;
   assign unused_inputs = zero;
`else
   assign trap          = 1'b0;
   assign unused_inputs = ^{zero, overflow, dec_q.ovf_chk};
`endif

   assign state_out = STATE_W'(state);

   // State sequencing, decode capture in ID, overflow sampling in EX
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IF;
         dec_q <= '0;
`ifdef OVERFLOW_TRAP_EN
         ovf_q <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IF: if (MIO_ready) state <= ST_ID;
            ST_ID: begin
               dec_q.alu_op  <= dec_alu_op;
               dec_q.illegal <= dec_illegal;
               dec_q.is_lw   <= (OPcode == OP_LW);
               dec_q.is_beq  <= (OPcode == OP_BEQ);
               dec_q.ovf_chk <= dec_ovf_chk;
               case (OPcode)
                  OP_RTYPE:                         state <= (Fun == FN_JR) ? ST_JR : ST_EX_R;
                  OP_LW, OP_SW:                     state <= ST_MEM_ADDR;
                  OP_BEQ, OP_BNE:                   state <= ST_BR;
                  OP_J:                             state <= ST_J;
                  OP_JAL:                           state <= ST_JAL;
                  OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state <= ST_EX_I;
                  OP_LUI:                           state <= ST_LUI;
                  default:                          state <= ST_ERROR;
               endcase
            end
            ST_EX_R: begin
`ifdef OVERFLOW_TRAP_EN
               ovf_q <= dec_q.ovf_chk & overflow;
`endif
               state <= dec_q.illegal ? ST_ERROR : ST_WB_R;
            end
            ST_EX_I: begin
`ifdef OVERFLOW_TRAP_EN
               ovf_q <= dec_q.ovf_chk & overflow;
`endif
               state <= ST_WB_I;
            end
            ST_WB_R, ST_WB_I: state <= trap ? ST_ERROR : ST_IF;
            ST_MEM_ADDR:      state <= dec_q.is_lw ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:        if (MIO_ready) state <= ST_WB_LW;
            ST_MEM_WR:        if (MIO_ready) state <= ST_IF;
            ST_WB_LW, ST_BR, ST_J, ST_JAL, ST_JR, ST_LUI: state <= ST_IF;
            ST_ERROR:         state <= ST_ERROR;
            default:          state <= ST_ERROR;
         endcase
      end
   end

   // Moore output decode; reset forces every enable and select to idle
   always_comb begin
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      IorD          = 1'b0;
      IRWrite       = 1'b0;
      RegDst        = REGDST_RT;
      RegWrite      = 1'b0;
      MemtoReg      = M2R_ALUOUT;
      ALUSrcA       = 1'b0;
      ALUSrcB       = SRCB_RT;
      PCSource      = PCSRC_ALU;
      PCWrite       = 1'b0;
      PCWriteCond   = 1'b0;
      Branch        = 1'b0;
      ALU_operation = ALU_ADD;
      exc           = 1'b0;
      if (!reset) begin
         case (state)
            ST_IF: begin
               MemRead = 1'b1;
               ALUSrcB = SRCB_FOUR;
               IRWrite = MIO_ready;
               PCWrite = MIO_ready;
            end
            ST_ID: ALUSrcB = SRCB_IMMSH;
            ST_EX_R: begin
               ALUSrcA       = 1'b1;
               ALU_operation = dec_q.alu_op;
            end
            ST_WB_R: begin
               RegDst   = REGDST_RD;
               RegWrite = !trap;
            end
            ST_EX_I: begin
               ALUSrcA       = 1'b1;
               ALUSrcB       = SRCB_IMM;
               ALU_operation = dec_q.alu_op;
            end
            ST_WB_I: RegWrite = !trap;
            ST_MEM_ADDR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
            end
            ST_MEM_RD: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            ST_WB_LW: begin
               MemtoReg = M2R_MDR;
               RegWrite = 1'b1;
            end
            ST_MEM_WR: begin
               MemWrite = 1'b1;
               IorD     = 1'b1;
            end
            ST_BR: begin
               ALUSrcA       = 1'b1;
               ALU_operation = ALU_SUB;
               PCWriteCond   = 1'b1;
               PCSource      = PCSRC_OUT;
               Branch        = dec_q.is_beq;
            end
            ST_J: begin
               PCSource = PCSRC_JMP;
               PCWrite  = 1'b1;
            end
            ST_JAL: begin
               PCSource = PCSRC_JMP;
               PCWrite  = 1'b1;
               RegDst   = REGDST_RA;
               MemtoReg = M2R_PC;
               RegWrite = 1'b1;
            end
            ST_JR: begin
               PCSource = PCSRC_RS;
               PCWrite  = 1'b1;
            end
            ST_LUI: begin
               MemtoReg = M2R_LUI;
               RegWrite = 1'b1;
            end
            ST_ERROR: exc = 1'b1;
            default:  exc = 1'b1;
         endcase
      end
      CPU_MIO = MemRead | MemWrite;
   end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: each instruction is expanded into the
// per-cycle control vector the controller should present, queued, and checked
// by an independent monitor on the falling edge.
module tb_multi_cycle_ctrl;

   logic       clk = 1'b0;
   logic       reset, zero, overflow, MIO_ready;
   logic [5:0] OPcode, Fun;
   logic       MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite;
   logic       ALUSrcA, PCWrite, PCWriteCond, Branch, exc;
   logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
   logic [2:0] ALU_operation;
   logic [4:0] state_out;

   multi_cycle_ctrl #(.STATE_W(5)) dut (
      .clk(clk), .reset(reset), .OPcode(OPcode), .Fun(Fun), .zero(zero),
      .overflow(overflow), .MIO_ready(MIO_ready), .MemRead(MemRead),
      .MemWrite(MemWrite), .CPU_MIO(CPU_MIO), .IorD(IorD), .IRWrite(IRWrite),
      .RegDst(RegDst), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch),
      .ALU_operation(ALU_operation), .exc(exc), .state_out(state_out)
   );

   always #5 clk = ~clk;

`ifdef OVERFLOW_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   typedef struct packed {
      logic [4:0] st;
      logic mrd, mwr, mio, iord, irw;
      logic [1:0] rdst;
      logic rw;
      logic [1:0] m2r;
      logic srca;
      logic [1:0] srcb, pcs;
      logic pcw, pcwc, br;
      logic [2:0] alu;
      logic exc;
   } ctl_t;

   typedef struct {
      ctl_t  c;
      string nm;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   logic [5:0] ops  [16] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02,
                             6'h03, 6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h0f, 6'h00, 6'h23};
   logic [5:0] funs [9]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h02, 6'h26, 6'h08};

   function automatic bit rb();
      return 1'($urandom);
   endfunction

   // Idle vector for a given state: nothing enabled, ALU at add
   function automatic ctl_t blank(input logic [4:0] st);
      ctl_t c = '0;
      c.st  = st;
      c.alu = 3'b010;
      return c;
   endfunction

   function automatic void r_alu(input logic [5:0] fn, output logic [2:0] alu, output bit ok);
      ok = 1'b1;
      case (fn)
         6'h20: alu = 3'b010;
         6'h22: alu = 3'b110;
         6'h24: alu = 3'b000;
         6'h25: alu = 3'b001;
         6'h27: alu = 3'b100;
         6'h2a: alu = 3'b111;
         6'h02: alu = 3'b101;
         6'h26: alu = 3'b011;
         default: begin alu = 3'b010; ok = 1'b0; end
      endcase
   endfunction

   // One clock of stimulus plus the control vector expected during it
   task automatic step(input ctl_t c, input string nm, input bit rdy, input bit ovf, input bit rst);
      exp_t e;
      @(posedge clk);
      #1;
      reset     = rst;
      MIO_ready = rdy;
      overflow  = ovf;
      zero      = rb();
      e.c  = c;
      e.nm = nm;
      exp_q.push_back(e);
   endtask

   // ERROR holds with exc set and no writes, then a one-cycle reset clears it
   task automatic error_tail();
      ctl_t c;
      for (int i = 0; i < 10; i++) begin
         c = blank(5'd31);
         c.exc = 1'b1;
         step(c, "ERROR", rb(), rb(), 1'b0);
      end
      step(blank(5'd31), "ERROR_rst", rb(), rb(), 1'b1);
   endtask

   task automatic do_instr(input logic [31:0] inst, input int if_stall, input int mem_stall,
                           input bit ovf_ex, input int abort_at);
      logic [5:0] op, fn;
      logic [2:0] alu;
      ctl_t       c;
      bit         ok, trap, lw;
      op = inst[31:26];
      fn = inst[5:0];
      for (int i = 0; i <= if_stall; i++) begin
         c = blank(5'd0);
         c.mrd = 1'b1; c.mio = 1'b1; c.srcb = 2'b01;
         if (i == if_stall) begin c.irw = 1'b1; c.pcw = 1'b1; end
         step(c, "IF", i == if_stall, rb(), 1'b0);
         OPcode = op;
         Fun    = fn;
      end
      c = blank(5'd1); c.srcb = 2'b11;
      step(c, "ID", rb(), rb(), 1'b0);
      case (op)
         6'h00: begin
            if (fn == 6'h08) begin
               c = blank(5'd13); c.pcs = 2'b11; c.pcw = 1'b1;
               step(c, "JR", rb(), rb(), 1'b0);
            end else begin
               r_alu(fn, alu, ok);
               c = blank(5'd2); c.srca = 1'b1; c.alu = alu;
               step(c, "EX_R", rb(), ovf_ex, 1'b0);
               if (!ok) begin
                  error_tail();
                  return;
               end
               trap = TRAP_EN && ovf_ex && (fn == 6'h20 || fn == 6'h22);
               c = blank(5'd3); c.rdst = 2'b01; c.rw = !trap;
               step(c, "WB_R", rb(), rb(), 1'b0);
               if (trap) error_tail();
            end
         end
         6'h08, 6'h0c, 6'h0d, 6'h0a: begin
            alu = (op == 6'h08) ? 3'b010 : (op == 6'h0c) ? 3'b000 : (op == 6'h0d) ? 3'b001 : 3'b111;
            c = blank(5'd4); c.srca = 1'b1; c.srcb = 2'b10; c.alu = alu;
            step(c, "EX_I", rb(), ovf_ex, 1'b0);
            trap = TRAP_EN && ovf_ex && (op == 6'h08);
            c = blank(5'd5); c.rw = !trap;
            step(c, "WB_I", rb(), rb(), 1'b0);
            if (trap) error_tail();
         end
         6'h23, 6'h2b: begin
            lw = (op == 6'h23);
            c = blank(5'd6); c.srca = 1'b1; c.srcb = 2'b10;
            step(c, "MEM_ADDR", rb(), rb(), 1'b0);
            for (int i = 0; i <= mem_stall; i++) begin
               if (i == abort_at) begin
                  step(blank(lw ? 5'd7 : 5'd9), "MEM_rst", rb(), rb(), 1'b1);
                  return;
               end
               c = blank(lw ? 5'd7 : 5'd9);
               c.mrd = lw; c.mwr = !lw; c.mio = 1'b1; c.iord = 1'b1;
               step(c, lw ? "MEM_RD" : "MEM_WR", i == mem_stall, rb(), 1'b0);
            end
            if (lw) begin
               c = blank(5'd8); c.m2r = 2'b01; c.rw = 1'b1;
               step(c, "WB_LW", rb(), rb(), 1'b0);
            end
         end
         6'h04, 6'h05: begin
            c = blank(5'd10); c.srca = 1'b1; c.alu = 3'b110; c.pcwc = 1'b1;
            c.pcs = 2'b01; c.br = (op == 6'h04);
            step(c, "BR", rb(), rb(), 1'b0);
         end
         6'h02: begin
            c = blank(5'd11); c.pcs = 2'b10; c.pcw = 1'b1;
            step(c, "J", rb(), rb(), 1'b0);
         end
         6'h03: begin
            c = blank(5'd12); c.pcs = 2'b10; c.pcw = 1'b1; c.rdst = 2'b10;
            c.m2r = 2'b10; c.rw = 1'b1;
            step(c, "JAL", rb(), rb(), 1'b0);
         end
         6'h0f: begin
            c = blank(5'd14); c.m2r = 2'b11; c.rw = 1'b1;
            step(c, "LUI", rb(), rb(), 1'b0);
         end
         default: error_tail();
      endcase
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      logic [5:0]  op;
      int unsigned k;
      w  = $urandom;
      k  = $urandom_range(0, 17);
      op = (k < 16) ? ops[k] : 6'($urandom);
      w[31:26] = op;
      if (op == 6'h00)
         w[5:0] = ($urandom_range(0, 9) == 9) ? 6'($urandom) : funs[$urandom_range(0, 8)];
      return w;
   endfunction

   // Monitor: one expected vector per clock, compared on the falling edge
   initial begin
      exp_t e;
      ctl_t a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{st: state_out, mrd: MemRead, mwr: MemWrite, mio: CPU_MIO, iord: IorD,
                  irw: IRWrite, rdst: RegDst, rw: RegWrite, m2r: MemtoReg, srca: ALUSrcA,
                  srcb: ALUSrcB, pcs: PCSource, pcw: PCWrite, pcwc: PCWriteCond,
                  br: Branch, alu: ALU_operation, exc: exc};
            total++;
            if (a !== e.c) begin
               bad++;
               $display("FAIL %s: got %h want %h", e.nm, a, e.c);
            end
         end
      end
   end

   initial begin
      reset = 1'b1; MIO_ready = 1'b0; overflow = 1'b0; zero = 1'b0;
      OPcode = '0; Fun = '0;
      step(blank(5'd0), "reset", 1'b0, 1'b0, 1'b1);

      do_instr(32'h00221820, 0, 0, 1'b0, -1);   // add
      do_instr(32'h8C220004, 0, 2, 1'b0, -1);   // lw, two memory stall cycles
      do_instr(32'h10220003, 0, 0, 1'b0, -1);   // beq
      do_instr(32'h14220003, 0, 0, 1'b0, -1);   // bne
      do_instr(32'h0C000010, 0, 0, 1'b0, -1);   // jal
      do_instr(32'hFC000000, 0, 0, 1'b0, -1);   // illegal opcode 0x3F
      do_instr(32'hAC220004, 0, 2, 1'b0, 1);    // sw, reset during stall
      do_instr(32'h00221820, 2, 0, 1'b1, -1);   // add, fetch stall, overflow
      do_instr(32'h20220005, 0, 0, 1'b1, -1);   // addi, overflow
      do_instr(32'h0022183F, 0, 0, 1'b0, -1);   // illegal funct
      do_instr(32'h03E00008, 0, 0, 1'b0, -1);   // jr
      do_instr(32'h3C01ABCD, 0, 0, 1'b0, -1);   // lui
      do_instr(32'h08000004, 1, 0, 1'b0, -1);   // j
      do_instr(32'hAC220004, 0, 1, 1'b0, -1);   // sw, one stall

      for (int n = 0; n < 250; n++)
         do_instr(rand_inst(), $urandom_range(0, 2), $urandom_range(0, 2), rb(),
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : -1);

      repeat (3) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Multi-cycle MIPS control FSM, directly upstream of the CPU data path.
- Decodes opcode/funct from the latched instruction register and sequences IF/ID/EX/MEM/WB.
- Drives every data-path control input: mux selects, write enables, PC update and ALU operation.
- Stalls on memory-not-ready.

Parameters:
- STATE_W, 5, width of the state register and of state_out.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- OPcode  input  6  Inst_R[31:26].
- Fun  input  6  Inst_R[5:0].
- zero  input  1  ALU zero flag from data path.
- overflow  input  1  ALU overflow flag from data path.
- MIO_ready  input  1  memory/IO transaction complete.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write strobe.
- CPU_MIO  output  1  bus request, =MemRead|MemWrite.
- IorD  output  1  0=PC address, 1=ALUOut address.
- IRWrite  output  1  latch instruction.
- RegDst  output  2  00=rt, 01=rd, 10=$31.
- RegWrite  output  1  register file write enable.
- MemtoReg  output  2  00=ALUOut, 01=MDR, 10=PC, 11=imm<<16.
- ALUSrcA  output  1  0=PC, 1=rs.
- ALUSrcB  output  2  00=rt, 01=4, 10=sext imm, 11=sext imm<<2.
- PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target, 11=rs.
- PCWrite  output  1  unconditional PC write.
- PCWriteCond  output  1  conditional PC write.
- Branch  output  1  1=beq (take on zero), 0=bne (take on !zero).
- ALU_operation  output  3  000 and, 001 or, 010 add, 110 sub, 111 slt, 100 nor, 101 srl, 011 xor.
- exc  output  1  exception/error flag.
- state_out  output  STATE_W  current state, for debug display.

Behaviour:
- Registered state; outputs are Moore-decoded from the state plus a registered decode of OPcode/Fun.
- Reset: state=IF; next cycle is a fresh fetch.
- Outputs with reset asserted: all enables and strobes 0, all selects 0, ALU_operation=010, exc=0.
- Reset overrides any stall or in-flight instruction.
- IF:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_operation=010, PCSource=00.
  - IRWrite=PCWrite=MIO_ready; hold IF while MIO_ready=0.
- ID: ALUSrcA=0, ALUSrcB=11, add (branch target into ALUOut). Dispatch on opcode:
  - 000000 → EX_R, or JR when Fun=001000.
  - 100011/101011 → MEM_ADDR.
  - 000100/000101 → BR.
  - 000010 → J; 000011 → JAL.
  - 001000/001100/001101/001010 → EX_I.
  - 001111 → LUI.
  - anything else → ERROR.
- EX_R: ALUSrcA=1, ALUSrcB=00. ALU_operation from Fun:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt, 000010 srl, 100110 xor.
  - Any other Fun → ERROR.
- WB_R: RegDst=01, MemtoReg=00, RegWrite=1 → IF.
- EX_I: ALUSrcA=1, ALUSrcB=10, op add/and/or/slt by opcode → WB_I.
- WB_I: RegDst=00, RegWrite=1 → IF.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, add → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: MemRead=1, IorD=1; hold until MIO_ready, then → WB_LW.
- WB_LW: RegDst=00, MemtoReg=01, RegWrite=1 → IF.
- MEM_WR: MemWrite=1, IorD=1; hold until MIO_ready, then → IF.
- BR: ALUSrcA=1, ALUSrcB=00, sub, PCWriteCond=1, PCSource=01, Branch=(opcode==000100) → IF.
- J: PCSource=10, PCWrite=1 → IF.
- JAL: PCSource=10, PCWrite=1, RegDst=10, MemtoReg=10, RegWrite=1 → IF. PC already holds PC+4.
- JR: PCSource=11, PCWrite=1 → IF.
- LUI: RegDst=00, MemtoReg=11, RegWrite=1 → IF.
- ERROR: exc=1, all writes 0; sticky until reset.
- Latency per instruction (IF counted as 1 cycle with MIO_ready=1):
  - R-type 4, I-type ALU 4, lw 5, sw 4, beq/bne 3, j/jal/jr 3, lui 3.
- Each MIO_ready=0 cycle adds one cycle.
- No write enable is ever asserted in two consecutive states for the same instruction.

Optional Feature:
- Macro: OVERFLOW_TRAP_EN.
- Defined:
  - overflow is sampled into a flag in EX_R (add/sub only) and EX_I (addi only).
  - If set, the WB state forces RegWrite=0 and transitions to ERROR; exc=1.
- Undefined: overflow is ignored, and exc is driven only by illegal opcode/funct.

Decomposition:
- Package ctrl_pkg holds:
  - state encodings: IF=0, ID=1, EX_R, WB_R, EX_I, WB_I, MEM_ADDR, MEM_RD, WB_LW, MEM_WR, BR, J, JAL, JR, LUI, ERROR=31;
  - opcode/funct constants;
  - ALU_operation and mux-select constants shared with the data path.
- One natural sub-module, alu_op_decode: combinational Fun/opcode → ALU_operation plus illegal flag.

Test Plan:
- add $3,$1,$2 (0x00221820), MIO_ready=1 → states IF,ID,EX_R,WB_R; RegWrite=1, RegDst=01 only in cycle 4; back in IF at cycle 5.
- lw $2,4($1) (0x8C220004), MIO_ready low 2 cycles in MEM_RD → MemRead/IorD=1 held 3 cycles; WB_LW MemtoReg=01; 7 cycles total.
- beq 0x10220003 → BR: PCWriteCond=1, Branch=1, PCSource=01, ALU_operation=110. bne 0x14220003 → Branch=0.
- jal 0x0C000010 → cycle 3: PCWrite=1, PCSource=10, RegDst=10, MemtoReg=10, RegWrite=1.
- opcode 0x3F → ERROR, exc=1, no writes for 10 cycles; reset=1 for one cycle → IF, exc=0.
- reset asserted during MEM_WR stall → next state IF, MemWrite=0. With OVERFLOW_TRAP_EN: add with overflow=1 in EX_R → RegWrite=0, exc=1.
